// File: rtl/spinner_quad_gen_pkg.sv
// spinner_pkg: shared types and helpers for the quadrature spinner emulator.
// Holds the Gray phase encoding, the per-direction next-phase functions,
// the step-direction encoding and the accumulator saturation limits.
package spinner_pkg;

  // Quadrature phase {A,B}. Exactly one bit changes between neighbours.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  localparam phase_t PHASE_RESET = PH_11;

  // Direction of the step taken on a tick.
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } dir_t;

  // Positive motion: 00 -> 10 -> 11 -> 01 -> 00
  function automatic phase_t phase_next_pos(phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_10;
      PH_10:   n = PH_11;
      PH_11:   n = PH_01;
      default: n = PH_00;
    endcase
    return n;
  endfunction

  // Negative motion: 00 -> 01 -> 11 -> 10 -> 00
  function automatic phase_t phase_next_neg(phase_t p);
    phase_t n;
    case (p)
      PH_00:   n = PH_01;
      PH_01:   n = PH_11;
      PH_11:   n = PH_10;
      default: n = PH_00;
    endcase
    return n;
  endfunction

  // Sign of a signed accumulator expressed as a step direction.
  function automatic dir_t dir_of(logic is_neg, logic is_zero);
    dir_t d;
    if (is_zero)     d = DIR_NONE;
    else if (is_neg) d = DIR_NEG;
    else             d = DIR_POS;
    return d;
  endfunction

  // Saturation limits of a two's-complement accumulator acc_w bits wide.
  function automatic int acc_max(int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  function automatic int acc_min(int acc_w);
    return -(1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/spinner_quad_gen_chan.sv
// spinner_chan: one spinner axis. Saturating signed position accumulator
// that is drained one count per prescaler tick, Gray phase register that
// steps toward zero, busy and sticky overflow flags.
// Optional keyboard auto-spin counter is built only when SPINNER_KEYS_EN
// is defined; otherwise the key inputs are ignored.
//
// Phase register states:
//   state | meaning
//   PH_11 | reset / idle phase
//   PH_10 | one step positive from 00 (or one step negative from 11)
//   PH_00 | half turn from reset phase
//   PH_01 | one step negative from 00 (or one step positive from 11)
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int DELTA_W       = 8,
  parameter int ACC_W         = 12,
  parameter int KEY_PERIOD    = 48000,
  parameter int KEY_STEP_SLOW = 4,
  parameter int KEY_STEP_FAST = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               delta_valid,
  input  logic [DELTA_W-1:0] delta,
  input  logic               key_pos,
  input  logic               key_neg,
  input  logic               key_fast,
  output logic [1:0]         quad,
  output logic               busy,
  output logic               overflow
);

  // Headroom for acc +/- 1 plus a delta plus a keyboard step before clamping.
  localparam int SUM_W = ACC_W + 3;
  localparam logic signed [SUM_W-1:0] ACC_MAX_S = SUM_W'(acc_max(ACC_W));
  localparam logic signed [SUM_W-1:0] ACC_MIN_S = SUM_W'(acc_min(ACC_W));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [SUM_W-1:0] dec;
  logic signed [SUM_W-1:0] delta_ext;
  logic signed [SUM_W-1:0] key_inj;
  logic signed [SUM_W-1:0] sum;
  logic                    clamp;
  dir_t                    step_dir;
  phase_t                  phase;

  assign quad = phase;

`ifdef SPINNER_KEYS_EN
  localparam int KCNT_W = (KEY_PERIOD > 1) ? $clog2(KEY_PERIOD) : 1;

  logic [KCNT_W-1:0]       key_cnt;
  logic                    key_one;
  logic                    key_fire;
  logic signed [SUM_W-1:0] key_mag;

  assign key_one  = key_pos ^ key_neg;
  assign key_fire = key_one && (key_cnt == KCNT_W'(KEY_PERIOD - 1));

  // Auto-spin period counter: runs only while exactly one key is held.
  always_ff @(posedge clk) begin
    if (!reset)                   key_cnt <= '0;
    else if (!key_one || key_fire) key_cnt <= '0;
    else                          key_cnt <= key_cnt + 1'b1;
  end

  // Signed keyboard injection on the wrap cycle.
  always_comb begin
    key_mag = key_fast ? SUM_W'(KEY_STEP_FAST) : SUM_W'(KEY_STEP_SLOW);
    key_inj = '0;
    if (key_fire) key_inj = key_pos ? key_mag : -key_mag;
  end
`else
  logic unused_keys;
  assign unused_keys = key_pos ^ key_neg ^ key_fast ^ (KEY_PERIOD == 0)
                       ^ (KEY_STEP_SLOW == 0) ^ (KEY_STEP_FAST == 0);
  assign key_inj = '0;
`endif

  // Next accumulator value: drain toward zero on tick, add injections, saturate.
  always_comb begin
    step_dir = DIR_NONE;
    if (tick) step_dir = dir_of(acc[ACC_W-1], acc == '0);
    case (step_dir)
      DIR_POS: dec = SUM_W'(1);
      DIR_NEG: dec = '1;
      default: dec = '0;
    endcase
    delta_ext = delta_valid ? SUM_W'($signed(delta)) : '0;
    sum       = SUM_W'(acc) - dec + delta_ext + key_inj;
    clamp     = 1'b0;
    if (sum > ACC_MAX_S) begin
      acc_next = ACC_MAX_S[ACC_W-1:0];
      clamp    = 1'b1;
    end else if (sum < ACC_MIN_S) begin
      acc_next = ACC_MIN_S[ACC_W-1:0];
      clamp    = 1'b1;
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
  end

  // Channel state: accumulator, phase step, busy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc      <= '0;
      phase    <= PHASE_RESET;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      acc  <= acc_next;
      busy <= (acc_next != '0);
      if (clamp) overflow <= 1'b1;
      case (step_dir)
        DIR_POS: phase <= phase_next_pos(phase);
        DIR_NEG: phase <= phase_next_neg(phase);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spinner_quad_gen.sv
// spinner_quad_gen: N-channel quadrature encoder emulator. Shared step-rate
// prescaler plus one spinner_chan per axis. Keyboard auto-spin is enabled
// by defining SPINNER_KEYS_EN; without it the key ports are ignored.
module spinner_quad_gen
  import spinner_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int DELTA_W       = 8,
  parameter int ACC_W         = 12,
  parameter int STEP_DIV      = 4,
  parameter int KEY_PERIOD    = 48000,
  parameter int KEY_STEP_SLOW = 4,
  parameter int KEY_STEP_FAST = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        delta_valid,
  input  logic [CHANNELS*DELTA_W-1:0] delta,
  input  logic [CHANNELS-1:0]         key_pos,
  input  logic [CHANNELS-1:0]         key_neg,
  input  logic                        key_fast,
  output logic [2*CHANNELS-1:0]       quad,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         overflow
);

  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(STEP_DIV - 1));

  // Shared prescaler: counts 0..STEP_DIV-1, tick on the last count.
  always_ff @(posedge clk) begin
    if (!reset)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    spinner_chan #(
      .DELTA_W      (DELTA_W),
      .ACC_W        (ACC_W),
      .KEY_PERIOD   (KEY_PERIOD),
      .KEY_STEP_SLOW(KEY_STEP_SLOW),
      .KEY_STEP_FAST(KEY_STEP_FAST)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .delta_valid(delta_valid),
      .delta      (delta[i*DELTA_W +: DELTA_W]),
      .key_pos    (key_pos[i]),
      .key_neg    (key_neg[i]),
      .key_fast   (key_fast),
      .quad       (quad[2*i +: 2]),
      .busy       (busy[i]),
      .overflow   (overflow[i])
    );
  end

endmodule

// File: tb/tb_spinner_quad_gen.sv
// Bench for spinner_quad_gen: two instances (fast and very slow step rate)
// share one stimulus stream and are compared every cycle against an
// arithmetic model (integer accumulator, phase index into a Gray table).
module tb_spinner_quad_gen;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int KP = 10;
  localparam int KS = 4;
  localparam int KF = 9;
  localparam int ND = 2;
  localparam int AMAX = 2047;
  localparam int AMIN = -2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               delta_valid;
  logic [CH*DW-1:0]   delta;
  logic [CH-1:0]      key_pos;
  logic [CH-1:0]      key_neg;
  logic               key_fast;
  logic [2*CH-1:0]    quad_o [ND];
  logic [CH-1:0]      busy_o [ND];
  logic [CH-1:0]      ovf_o  [ND];

  spinner_quad_gen #(
    .CHANNELS(CH), .DELTA_W(DW), .ACC_W(AW), .STEP_DIV(4),
    .KEY_PERIOD(KP), .KEY_STEP_SLOW(KS), .KEY_STEP_FAST(KF)
  ) u_dut_fast (
    .clk(clk), .reset(reset), .delta_valid(delta_valid), .delta(delta),
    .key_pos(key_pos), .key_neg(key_neg), .key_fast(key_fast),
    .quad(quad_o[0]), .busy(busy_o[0]), .overflow(ovf_o[0])
  );

  spinner_quad_gen #(
    .CHANNELS(CH), .DELTA_W(DW), .ACC_W(AW), .STEP_DIV(4096),
    .KEY_PERIOD(KP), .KEY_STEP_SLOW(KS), .KEY_STEP_FAST(KF)
  ) u_dut_slow (
    .clk(clk), .reset(reset), .delta_valid(delta_valid), .delta(delta),
    .key_pos(key_pos), .key_neg(key_neg), .key_fast(key_fast),
    .quad(quad_o[1]), .busy(busy_o[1]), .overflow(ovf_o[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int m_div [ND] = '{4, 4096};
  int m_pc  [ND];
  int m_acc [ND][CH];
  int m_pos [ND][CH];
  bit m_ovf [ND][CH];
`ifdef SPINNER_KEYS_EN
  int m_kc  [ND][CH];
`endif
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < ND; d++) begin
      bit tk;
      tk = (m_pc[d] == m_div[d] - 1);
      if (!reset) m_pc[d] = 0;
      else        m_pc[d] = tk ? 0 : m_pc[d] + 1;
      for (int c = 0; c < CH; c++) begin
        int inj;
        int nxt;
        if (!reset) begin
          m_acc[d][c] = 0;
          m_pos[d][c] = 2;
          m_ovf[d][c] = 1'b0;
`ifdef SPINNER_KEYS_EN
          m_kc[d][c]  = 0;
`endif
        end else begin
          inj = delta_valid ? int'($signed(delta[c*DW +: DW])) : 0;
`ifdef SPINNER_KEYS_EN
          if (key_pos[c] == key_neg[c]) m_kc[d][c] = 0;
          else if (m_kc[d][c] == KP - 1) begin
            m_kc[d][c] = 0;
            inj += (key_pos[c] ? 1 : -1) * (key_fast ? KF : KS);
          end else m_kc[d][c]++;
`endif
          nxt = m_acc[d][c] + inj;
          if (tk && m_acc[d][c] > 0) begin
            m_pos[d][c] = (m_pos[d][c] + 1) % 4;
            nxt -= 1;
          end else if (tk && m_acc[d][c] < 0) begin
            m_pos[d][c] = (m_pos[d][c] + 3) % 4;
            nxt += 1;
          end
          if (nxt > AMAX) begin nxt = AMAX; m_ovf[d][c] = 1'b1; end
          if (nxt < AMIN) begin nxt = AMIN; m_ovf[d][c] = 1'b1; end
          m_acc[d][c] = nxt;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      logic [2*CH-1:0] eq;
      logic [CH-1:0]   eb;
      logic [CH-1:0]   eo;
      for (int c = 0; c < CH; c++) begin
        eq[2*c +: 2] = gray[m_pos[d][c]];
        eb[c] = (m_acc[d][c] != 0);
        eo[c] = m_ovf[d][c];
      end
      check_eq($sformatf("quad_dut%0d", d), 32'(quad_o[d]), 32'(eq));
      check_eq($sformatf("busy_dut%0d", d), 32'(busy_o[d]), 32'(eb));
      check_eq($sformatf("ovf_dut%0d", d),  32'(ovf_o[d]),  32'(eo));
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    delta_valid = 1'b0;
    delta       = '0;
    key_pos     = '0;
    key_neg     = '0;
    key_fast    = 1'b0;
  endtask

  task automatic do_reset(int n);
    idle_inputs();
    reset = 1'b0;
    for (int k = 0; k < n; k++) step_clk();
    reset = 1'b1;
  endtask

  task automatic pulse_delta(logic [DW-1:0] d0, logic [DW-1:0] d1);
    delta_valid = 1'b1;
    delta       = {d1, d0};
    step_clk();
    delta_valid = 1'b0;
    delta       = '0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) m_pc[d] = 0;
    for (int d = 0; d < ND; d++)
      for (int c = 0; c < CH; c++) begin
        m_acc[d][c] = 0;
        m_pos[d][c] = 2;
        m_ovf[d][c] = 1'b0;
`ifdef SPINNER_KEYS_EN
        m_kc[d][c]  = 0;
`endif
      end

    // reset state
    do_reset(3);
    check_eq("rst_quad", 32'(quad_o[0]), 32'h0000000F);
    check_eq("rst_busy", 32'(busy_o[0]), 32'h0);
    check_eq("rst_ovf",  32'(ovf_o[0]),  32'h0);

    // +3 on ch0: three steps 11->01->00->10 at ticks 4, 8, 12
    pulse_delta(8'd3, 8'd0);
    check_eq("plus3_busy", 32'(busy_o[0]), 32'h1);
    for (int k = 0; k < 11; k++) step_clk();
    check_eq("plus3_quad", 32'(quad_o[0]), 32'hE);
    check_eq("plus3_idle", 32'(busy_o[0]), 32'h0);

    // -2 on ch0: 11->10->00 then hold
    do_reset(1);
    pulse_delta(8'hFE, 8'd0);
    for (int k = 0; k < 7; k++) step_clk();
    check_eq("minus2_quad", 32'(quad_o[0]), 32'hC);
    for (int k = 0; k < 8; k++) step_clk();
    check_eq("minus2_hold", 32'(quad_o[0]), 32'hC);
    check_eq("minus2_ovf",  32'(ovf_o[0]),  32'h0);

    // saturation: 20 x +127
    do_reset(1);
    delta_valid = 1'b1;
    delta       = {8'd0, 8'd127};
    for (int k = 0; k < 20; k++) step_clk();
    idle_inputs();
    check_eq("sat_ovf_slow", 32'(ovf_o[1]), 32'h1);
    check_eq("sat_ovf_fast", 32'(ovf_o[0]), 32'h1);
    do_reset(1);
    check_eq("sat_clr_ovf",  32'(ovf_o[1]),  32'h0);
    check_eq("sat_clr_quad", 32'(quad_o[1]), 32'hF);

    // delta on the same edge as a tick with acc0 = +1
    pulse_delta(8'd1, 8'd0);
    step_clk();
    step_clk();
    pulse_delta(8'd1, 8'd0);
    check_eq("tickdelta_busy", 32'(busy_o[0]), 32'h1);
    check_eq("tickdelta_quad", 32'(quad_o[0]), 32'hD);
    for (int k = 0; k < 4; k++) step_clk();
    check_eq("tickdelta_q2", 32'(quad_o[0]), 32'hC);
    check_eq("tickdelta_b2", 32'(busy_o[0]), 32'h0);

    // keyboard: key_neg[1] fast, then both keys
    do_reset(1);
    key_neg[1] = 1'b1;
    key_fast   = 1'b1;
    for (int k = 0; k < 12; k++) step_clk();
`ifdef SPINNER_KEYS_EN
    check_eq("key_busy", 32'(busy_o[0][1]), 32'h1);
`else
    check_eq("key_busy", 32'(busy_o[0][1]), 32'h0);
`endif
    for (int k = 0; k < 33; k++) step_clk();
    key_pos[1] = 1'b1;
    for (int k = 0; k < 25; k++) step_clk();
    idle_inputs();

    // reset mid-rotation
    do_reset(1);
    pulse_delta(8'd50, 8'd0);
    for (int k = 0; k < 20; k++) step_clk();
    reset = 1'b0;
    step_clk();
    check_eq("midrst_quad", 32'(quad_o[0]), 32'hF);
    check_eq("midrst_busy", 32'(busy_o[0]), 32'h0);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) step_clk();
    check_eq("midrst_hold", 32'(quad_o[0]), 32'hF);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 399) != 0);
      delta_valid = ($urandom_range(0, 3) == 0);
      delta       = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        key_pos  = 2'($urandom);
        key_neg  = 2'($urandom);
        key_fast = 1'($urandom);
      end
      step_clk();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
